// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control FSM: sequences fetch/decode/execute/memory/writeback
// for one instruction at a time and counts retired instructions.
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        lt,
  input  logic        ltu,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_write,
  output logic        adr_src,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_control,
  output logic [2:0]  imm_src,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_PASS = 4'b1010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRPC,
    S_LUI, S_AUIPC, S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] instret_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       unused_instr_bits;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7_5 = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // Shared R/I-type operation decode; SUB only exists in the register form.
  function automatic logic [3:0] funct_op(input logic [2:0] f3, input logic f7_5,
                                          input logic is_r);
    case (f3)
      3'b000:  funct_op = (is_r && f7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  funct_op = ALU_SLL;
      3'b010:  funct_op = ALU_SLT;
      3'b011:  funct_op = ALU_SLTU;
      3'b100:  funct_op = ALU_XOR;
      3'b101:  funct_op = f7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  funct_op = ALU_OR;
      default: funct_op = ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_FETCH && state_q != S_FETCH)
        instret_q <= instret_q + XLEN'(1);
    end
  end

  assign instret = instret_q;

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    imm_src     = 3'b000;
    illegal     = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      // Branch/jump target is precomputed into alu_out here.
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_JAL) ? 3'b011 : 3'b010;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = (funct3 == 3'b010) ? S_MEMADR : S_HALT;
          OP_R:      state_d = S_EXECR;
          OP_I:      state_d = S_EXECI;
          OP_BRANCH: state_d = (funct3[2:1] == 2'b01) ? S_HALT : S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          OP_AUIPC:  state_d = S_AUIPC;
          default:   state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (opcode == OP_STORE) begin
          imm_src = 3'b001;
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = funct_op(funct3, funct7_5, 1'b1);
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = funct_op(funct3, funct7_5, 1'b0);
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        case (funct3)
          3'b000:  pc_write = zero;
          3'b001:  pc_write = ~zero;
          3'b100:  pc_write = lt;
          3'b101:  pc_write = ~lt;
          3'b110:  pc_write = ltu;
          3'b111:  pc_write = ~ltu;
          default: pc_write = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      // Link value old_pc+4 lands in alu_out while the target is written to PC.
      S_JAL, S_JALRPC: begin
        pc_write  = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = S_JALRPC;
      end
      S_LUI: begin
        alu_src_b   = 2'b01;
        imm_src     = 3'b100;
        alu_control = ALU_PASS;
        state_d     = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 3'b100;
        state_d   = S_ALUWB;
      end
      S_HALT: illegal = 1'b1;
      default: state_d = S_HALT;
    endcase

    // Architectural writes are suppressed while reset is held.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle stimulus and expected controls
// are queued per instruction, then replayed and compared one cycle at a time.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero, lt, ltu, mem_ready;
  logic        pc_write, ir_write, reg_write, mem_write, adr_src, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [3:0]  alu_control;
  logic [2:0]  imm_src;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_write(mem_write), .adr_src(adr_src),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .illegal(illegal),
    .instret(instret)
  );

  localparam logic [3:0] A_ADD = 4'b0000, A_SUB = 4'b0001, A_SRL = 4'b0110,
                         A_SRA = 4'b0111, A_SLTU = 4'b1001, A_PASS = 4'b1010;

  typedef struct {
    string       tag;
    logic        rst, mr, z, l, lu;
    logic [31:0] ins;
    logic [18:0] ctl;
    logic [31:0] cnt;
  } step_t;

  step_t       sb_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] ret = 32'd0;
  logic [31:0] cur_instr = 32'd0;
  logic        cur_z = 1'b0, cur_l = 1'b0, cur_lu = 1'b0;

  // Packed control word: {pcw,irw,rw,mw,adr,result,src_a,src_b,alu,imm,illegal}
  function automatic logic [18:0] ctl(input logic pcw, input logic irw, input logic rw,
                                      input logic mw, input logic adr, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [3:0] alu, input logic [2:0] imm,
                                      input logic ill);
    return {pcw, irw, rw, mw, adr, rs, sa, sb, alu, imm, ill};
  endfunction

  function automatic logic [18:0] c_fetch(input logic mr);
    return ctl(mr, mr, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, A_ADD, 3'b000, 1'b0);
  endfunction
  function automatic logic [18:0] c_dec(input logic [2:0] imm);
    return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, A_ADD, imm, 1'b0);
  endfunction
  function automatic logic [18:0] c_execr(input logic [3:0] alu);
    return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, alu, 3'b000, 1'b0);
  endfunction
  function automatic logic [18:0] c_execi(input logic [3:0] alu);
    return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, alu, 3'b000, 1'b0);
  endfunction
  function automatic logic [18:0] c_wb(input logic [1:0] rs);
    return ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rs, 2'b00, 2'b00, A_ADD, 3'b000, 1'b0);
  endfunction
  function automatic logic [18:0] c_memadr(input logic [2:0] imm);
    return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, A_ADD, imm, 1'b0);
  endfunction
  function automatic logic [18:0] c_mem(input logic mw);
    return ctl(1'b0, 1'b0, 1'b0, mw, 1'b1, 2'b00, 2'b00, 2'b00, A_ADD, 3'b000, 1'b0);
  endfunction
  function automatic logic [18:0] c_branch(input logic pcw);
    return ctl(pcw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, A_SUB, 3'b000, 1'b0);
  endfunction

  task automatic push(input string tag, input logic rst, input logic mr, input logic [18:0] c);
    step_t s;
    s.tag = tag; s.rst = rst; s.mr = mr;
    s.z = cur_z; s.l = cur_l; s.lu = cur_lu;
    s.ins = cur_instr; s.ctl = c; s.cnt = ret;
    sb_q.push_back(s);
  endtask

  task automatic alu_instr(input string tag, input logic [31:0] ins, input logic is_r,
                           input logic [3:0] alu);
    cur_instr = ins;
    push({tag, "_fetch"}, 1'b0, 1'b1, c_fetch(1'b1));
    push({tag, "_decode"}, 1'b0, 1'b1, c_dec(3'b010));
    push({tag, "_exec"}, 1'b0, 1'b1, is_r ? c_execr(alu) : c_execi(alu));
    push({tag, "_aluwb"}, 1'b0, 1'b1, c_wb(2'b00));
    ret = ret + 32'd1;
  endtask

  task automatic branch_instr(input string tag, input logic [31:0] ins, input logic z,
                              input logic l, input logic lu, input logic taken);
    cur_instr = ins; cur_z = z; cur_l = l; cur_lu = lu;
    push({tag, "_fetch"}, 1'b0, 1'b1, c_fetch(1'b1));
    push({tag, "_decode"}, 1'b0, 1'b1, c_dec(3'b010));
    push({tag, "_branch"}, 1'b0, 1'b1, c_branch(taken));
    ret = ret + 32'd1;
  endtask

  // Replay queued steps: drive after the rising edge, check on the falling edge.
  task automatic drain();
    step_t       s;
    logic [18:0] obs;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      reset = s.rst; mem_ready = s.mr; zero = s.z; lt = s.l; ltu = s.lu; instr = s.ins;
      @(negedge clk);
      obs = {pc_write, ir_write, reg_write, mem_write, adr_src, result_src,
             alu_src_a, alu_src_b, alu_control, imm_src, illegal};
      tests++;
      assert (obs === s.ctl) else begin
        fails++;
        $error("FAIL %s ctl observed=%b expected=%b", s.tag, obs, s.ctl);
      end
      tests++;
      assert (instret === s.cnt) else begin
        fails++;
        $error("FAIL %s instret observed=%0d expected=%0d", s.tag, instret, s.cnt);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0; instr = 32'd0;
    repeat (2) @(posedge clk);
    #1;

    push("reset_fetch_stall", 1'b0, 1'b0, c_fetch(1'b0));
    alu_instr("add",  32'h002081B3, 1'b1, A_ADD);
    alu_instr("sub",  32'h402081B3, 1'b1, A_SUB);
    alu_instr("srai", 32'h4020D193, 1'b0, A_SRA);
    alu_instr("addi_b30", 32'h40008093, 1'b0, A_ADD);
    alu_instr("srl",  32'h0020D1B3, 1'b1, A_SRL);
    alu_instr("sltu", 32'h0020B1B3, 1'b1, A_SLTU);

    cur_instr = 32'h0000A183;
    push("lw_fetch", 1'b0, 1'b1, c_fetch(1'b1));
    push("lw_decode", 1'b0, 1'b1, c_dec(3'b010));
    push("lw_memadr", 1'b0, 1'b1, c_memadr(3'b000));
    push("lw_memread0", 1'b0, 1'b0, c_mem(1'b0));
    push("lw_memread1", 1'b0, 1'b0, c_mem(1'b0));
    push("lw_memread2", 1'b0, 1'b1, c_mem(1'b0));
    push("lw_memwb", 1'b0, 1'b1, c_wb(2'b01));
    ret = ret + 32'd1;

    cur_instr = 32'h0020A223;
    push("sw_fetch", 1'b0, 1'b1, c_fetch(1'b1));
    push("sw_decode", 1'b0, 1'b1, c_dec(3'b010));
    push("sw_memadr", 1'b0, 1'b1, c_memadr(3'b001));
    push("sw_memwrite", 1'b0, 1'b1, c_mem(1'b1));
    ret = ret + 32'd1;

    branch_instr("beq_taken", 32'h00208463, 1'b1, 1'b0, 1'b0, 1'b1);
    branch_instr("beq_not",   32'h00208463, 1'b0, 1'b1, 1'b1, 1'b0);
    branch_instr("bne_eq",    32'h00209463, 1'b1, 1'b0, 1'b0, 1'b0);
    branch_instr("bltu_lt",   32'h0020E463, 1'b0, 1'b0, 1'b1, 1'b1);
    cur_z = 1'b0; cur_l = 1'b0; cur_lu = 1'b0;

    cur_instr = 32'h008000EF;
    push("jal_fetch", 1'b0, 1'b1, c_fetch(1'b1));
    push("jal_decode", 1'b0, 1'b1, c_dec(3'b011));
    push("jal_jal", 1'b0, 1'b1,
         ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, A_ADD, 3'b000, 1'b0));
    push("jal_aluwb", 1'b0, 1'b1, c_wb(2'b00));
    ret = ret + 32'd1;

    cur_instr = 32'h000010B7;
    push("lui_fetch", 1'b0, 1'b1, c_fetch(1'b1));
    push("lui_decode", 1'b0, 1'b1, c_dec(3'b010));
    push("lui_lui", 1'b0, 1'b1,
         ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, A_PASS, 3'b100, 1'b0));
    push("lui_aluwb", 1'b0, 1'b1, c_wb(2'b00));
    ret = ret + 32'd1;
    drain();

    cur_instr = 32'hFFFFFFFF;
    push("ill_fetch", 1'b0, 1'b1, c_fetch(1'b1));
    push("ill_decode", 1'b0, 1'b1, c_dec(3'b010));
    for (int i = 0; i < 22; i++)
      push("ill_halt", 1'b0, 1'((i % 3) != 0),
           ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A_ADD, 3'b000, 1'b1));
    push("ill_reset", 1'b1, 1'b1,
         ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A_ADD, 3'b000, 1'b1));
    ret = 32'd0;
    push("ill_after_reset", 1'b0, 1'b0, c_fetch(1'b0));
    alu_instr("add2", 32'h002081B3, 1'b1, A_ADD);

    cur_instr = 32'h0020A223;
    push("swr_fetch", 1'b0, 1'b1, c_fetch(1'b1));
    push("swr_decode", 1'b0, 1'b1, c_dec(3'b010));
    push("swr_memadr", 1'b0, 1'b1, c_memadr(3'b001));
    push("swr_memwrite_wait", 1'b0, 1'b0, c_mem(1'b1));
    push("swr_reset", 1'b1, 1'b0, c_mem(1'b0));
    ret = 32'd0;
    push("swr_after_reset", 1'b0, 1'b0, c_fetch(1'b0));
    push("fetch_reset_gate", 1'b1, 1'b1, c_fetch(1'b0));
    push("fetch_after_reset", 1'b0, 1'b0, c_fetch(1'b0));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
